// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences the shared memory, regfile and ALU.
// Optional build macro MULTICYCLE_PERF_CNT_EN adds cycle_cnt / instret_cnt counters.
//
//  state         | meaning
//  FETCH    (0)  | read instr at PC, PC <= PC + 4 once memory is ready
//  DECODE   (1)  | read regfile, compute branch target OldPC + imm
//  MEMADR   (2)  | compute load/store address RD1 + imm
//  MEMREAD  (3)  | read data memory, wait for mem_ready
//  MEMWB    (4)  | write loaded data to rd
//  MEMWRITE (5)  | write data memory, wait for mem_ready
//  EXECR    (6)  | ALU on RD1, RD2
//  EXECI    (7)  | ALU on RD1, imm
//  ALUWB    (8)  | write ALUOut to rd
//  BEQ      (9)  | compare, take branch target on zero
//  JAL      (10) | PC <= target, ALU computes OldPC + 4 for link
//  ERROR    (15) | unsupported encoding, sticky until reset
module multicycle_ctrl #(
   parameter int STATE_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [6:0]             op,
   input  logic [2:0]             funct3,
   input  logic                   funct7b5,
   input  logic                   zero,
   input  logic                   mem_ready,
   output logic                   PCWrite,
   output logic                   AdrSrc,
   output logic                   IRWrite,
   output logic                   MemWrite,
   output logic                   RegWrite,
   output logic [1:0]             ResultSrc,
   output logic [1:0]             ALUSrcA,
   output logic [1:0]             ALUSrcB,
   output logic [2:0]             ALUctrl,
   output logic [1:0]             ImmSrc,
   output logic                   illegal,
   output logic [STATE_WIDTH-1:0] state
`ifdef MULTICYCLE_PERF_CNT_EN
   ,
   output logic [31:0]            cycle_cnt,
   output logic [31:0]            instret_cnt
`endif
);

   localparam logic [STATE_WIDTH-1:0] S_FETCH    = STATE_WIDTH'(0);
   localparam logic [STATE_WIDTH-1:0] S_DECODE   = STATE_WIDTH'(1);
   localparam logic [STATE_WIDTH-1:0] S_MEMADR   = STATE_WIDTH'(2);
   localparam logic [STATE_WIDTH-1:0] S_MEMREAD  = STATE_WIDTH'(3);
   localparam logic [STATE_WIDTH-1:0] S_MEMWB    = STATE_WIDTH'(4);
   localparam logic [STATE_WIDTH-1:0] S_MEMWRITE = STATE_WIDTH'(5);
   localparam logic [STATE_WIDTH-1:0] S_EXECR    = STATE_WIDTH'(6);
   localparam logic [STATE_WIDTH-1:0] S_EXECI    = STATE_WIDTH'(7);
   localparam logic [STATE_WIDTH-1:0] S_ALUWB    = STATE_WIDTH'(8);
   localparam logic [STATE_WIDTH-1:0] S_BEQ      = STATE_WIDTH'(9);
   localparam logic [STATE_WIDTH-1:0] S_JAL      = STATE_WIDTH'(10);
   localparam logic [STATE_WIDTH-1:0] S_ERROR    = STATE_WIDTH'(15);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic [STATE_WIDTH-1:0] state_q;
   logic [STATE_WIDTH-1:0] state_d;
   logic                   funct_ok;
   logic [2:0]             alu_funct;

   assign funct_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

   always_ff @(posedge clk) begin
      if (!rst) state_q <= S_FETCH;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = S_ERROR;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = funct_ok ? S_EXECR : S_ERROR;
               OP_I:         state_d = funct_ok ? S_EXECI : S_ERROR;
               OP_BEQ:       state_d = (funct3 == 3'b000) ? S_BEQ : S_ERROR;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_ERROR;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_ERROR;
      endcase
   end

   // Subtract only exists for register-register ops; addi ignores instr[30].
   always_comb begin
      alu_funct = 3'b000;
      case (funct3)
         3'b000:  alu_funct = (op == OP_R && funct7b5) ? 3'b001 : 3'b000;
         3'b010:  alu_funct = 3'b101;
         3'b110:  alu_funct = 3'b011;
         3'b111:  alu_funct = 3'b010;
         default: alu_funct = 3'b000;
      endcase
   end

   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUctrl   = 3'b000;
      case (state_q)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            PCWrite   = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUctrl = alu_funct;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUctrl = alu_funct;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUctrl = 3'b001;
            PCWrite = zero;
         end
         S_JAL: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            PCWrite = 1'b1;
         end
         default: ;
      endcase
      // No architectural write may slip out while reset is asserted.
      if (!rst) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
      end
   end

   always_comb begin
      ImmSrc = 2'b00;
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   assign illegal = (state_q == S_ERROR);
   assign state   = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
   logic retire;

   assign retire = (state_d == S_FETCH) &&
                   (state_q == S_MEMWB || state_q == S_MEMWRITE ||
                    state_q == S_ALUWB || state_q == S_BEQ);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt   <= 32'd0;
         instret_cnt <= 32'd0;
      end else begin
         if (state_q != S_ERROR) cycle_cnt <= cycle_cnt + 32'd1;
         if (retire)             instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule
